gaussian_clt: RTL

- Downstream consumer of the 43-bit LFSR/cellular-automaton PRNG (32-bit uniform output).
- Sums NUM_SUM uniform samples (central-limit approximation) and subtracts the mean, producing a signed, zero-mean, approximately Gaussian fixed-point value.
- Drives the PRNG's fetchNewSample request line.
- Output goes to the RNN weight-init/noise-injection path through a valid/ready handshake.

---
 rtl/rng_pkg.sv | 23 ++
 rtl/gaussian_clt_if.sv | 32 +++
 rtl/uniform_accumulator.sv | 48 ++++
 rtl/gaussian_clt.sv | 119 +++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared constants and FSM encoding for the PRNG-to-Gaussian sample path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: PRNG widths, default CLT parameters, derived mean, state encoding.
package rng_pkg;

  localparam int IN_size   = 32;  // width of the PRNG uniform output
  localparam int LFSR_size = 43;  // internal state width of the upstream PRNG
  localparam int UNI_bits  = 12;  // MSBs taken from each uniform sample
  localparam int LOG2_SUM  = 2;   // log2 of the number of samples summed
  localparam int OUT_size  = 16;  // signed output width

  localparam int NUM_SUM = 1 << LOG2_SUM;
  // Expected value of the sum: NUM_SUM uniforms, each centred on 2^(UNI_bits-1).
  localparam int MEAN    = NUM_SUM * (1 << (UNI_bits - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/gaussian_clt_if.sv
// PRNG request/data lines plus the valid/ready output stream of gaussian_clt.
// Latency: n/a (wiring only).
// Backpressure: gaussReady from the consumer stalls the generator in S_OUT.
// master = generator side (drives fetch, sample, valid); slave = PRNG + consumer.
interface gaussian_clt_if #(
  parameter int IN_size  = 32,
  parameter int OUT_size = 16
);

  logic                fetchNewSample;
  logic [IN_size-1:0]  randomArray;
  logic [OUT_size-1:0] gaussOut;
  logic                gaussValid;
  logic                gaussReady;

  modport master (
    output fetchNewSample,
    output gaussOut,
    output gaussValid,
    input  randomArray,
    input  gaussReady
  );

  modport slave (
    input  fetchNewSample,
    input  gaussOut,
    input  gaussValid,
    output randomArray,
    output gaussReady
  );

endinterface

// File: rtl/uniform_accumulator.sv
// Sums the uniforms that arrive one cycle after each fetch; flags the last one.
// Latency: a fetch in cycle n is captured at the end of cycle n+1.
// Backpressure: none; clear has priority and discards any partial sum.
// Ports: clock/reset, clear, fetch, uniform in; acc_sum (acc + uniform), last_capture out.
module uniform_accumulator #(
  parameter int UNI_bits = 12,
  parameter int LOG2_SUM = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         fetch,
  input  logic [UNI_bits-1:0]          uniform,
  output logic [UNI_bits+LOG2_SUM-1:0] acc_sum,
  output logic                         last_capture
);

  localparam int ACCW = UNI_bits + LOG2_SUM;
  localparam logic [LOG2_SUM:0] LAST_CAP = (LOG2_SUM + 1)'((1 << LOG2_SUM) - 1);

  logic            pending;  // the PRNG data on the bus this cycle answers a fetch
  logic [LOG2_SUM:0] cap_cnt;
  logic [ACCW-1:0] acc_q;

  // acc_sum is the running total including the current bus sample; it is only
  // meaningful while pending is high.
  assign acc_sum      = acc_q + ACCW'(uniform);
  assign last_capture = pending && (cap_cnt == LAST_CAP);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending <= 1'b0;
      cap_cnt <= '0;
      acc_q   <= '0;
    end else if (clear) begin
      pending <= 1'b0;
      cap_cnt <= '0;
      acc_q   <= '0;
    end else begin
      pending <= fetch;
      if (pending) begin
        acc_q   <= acc_sum;
        cap_cnt <= cap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gaussian_clt.sv
// Central-limit Gaussian: sums NUM_SUM uniform PRNG samples and removes the mean.
// Latency: NUM_SUM+1 cycles from entering S_ACC to gaussValid; one sample per NUM_SUM+2 cycles.
// Backpressure: holds gaussOut/gaussValid and issues no fetches until gaussReady.
// Ports: clock, reset (sync, active-low), enableGauss, busy; bus = PRNG fetch/data + output stream.
module gaussian_clt #(
  parameter int IN_size  = rng_pkg::IN_size,
  parameter int UNI_bits = rng_pkg::UNI_bits,
  parameter int LOG2_SUM = rng_pkg::LOG2_SUM,
  parameter int OUT_size = rng_pkg::OUT_size
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enableGauss,
  output logic           busy,
  gaussian_clt_if.master bus
);

  import rng_pkg::*;

  // OUT_size must be at least UNI_bits+LOG2_SUM+1 so the centred sum fits.
  localparam int NSUM = 1 << LOG2_SUM;
  localparam int ACCW = UNI_bits + LOG2_SUM;
  localparam logic [ACCW:0]     MEAN_V    = (ACCW + 1)'(NSUM * (1 << (UNI_bits - 1)));
  localparam logic [LOG2_SUM:0] FETCH_MAX = (LOG2_SUM + 1)'(NSUM);

  state_t              state_q, state_d;
  logic [LOG2_SUM:0]   fetch_cnt;
  logic                fetch, clear, load, handshake;
  logic [ACCW-1:0]     acc_sum;
  logic                last_capture;
  logic signed [ACCW:0] centered;
  logic [OUT_size-1:0] out_q;
  logic                valid_q;
  logic [UNI_bits-1:0] uniform;
  logic                unused_lsbs;

  assign uniform     = bus.randomArray[IN_size-1 -: UNI_bits];
  assign unused_lsbs = ^bus.randomArray[IN_size-UNI_bits-1:0];

  // One extra bit above the accumulator makes the subtraction a proper signed
  // result; the sum never exceeds 2*MEAN so no saturation is needed.
  assign centered  = $signed({1'b0, acc_sum} - MEAN_V);
  assign handshake = valid_q & bus.gaussReady;
  assign busy      = (state_q != S_IDLE);

  assign bus.fetchNewSample = fetch;
  assign bus.gaussOut       = out_q;
  assign bus.gaussValid     = valid_q;

  uniform_accumulator #(
    .UNI_bits (UNI_bits),
    .LOG2_SUM (LOG2_SUM)
  ) u_acc (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .fetch        (fetch),
    .uniform      (uniform),
    .acc_sum      (acc_sum),
    .last_capture (last_capture)
  );

  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    clear   = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enableGauss) begin
          state_d = S_ACC;
          clear   = 1'b1;
        end
      end
      S_ACC: begin
        // Enable is deliberately ignored here: a started sample always completes.
        fetch = (fetch_cnt < FETCH_MAX);
        if (last_capture) begin
          state_d = S_OUT;
          load    = 1'b1;
        end
      end
      S_OUT: begin
        if (handshake) begin
          if (enableGauss) begin
            state_d = S_ACC;
            clear   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      fetch_cnt <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        fetch_cnt <= '0;
      end else if (fetch) begin
        fetch_cnt <= fetch_cnt + 1'b1;
      end
      if (load) begin
        out_q   <= OUT_size'(centered);
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
